mux_l2_arb: RTL and testbench

MUX_L2_ARB -- requirements
Module: mux_l2_arb

---
 rtl/mux_l2_arb.sv | 79 +++++++
 tb/tb_mux_l2_arb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_l2_arb.sv
// mux_l2_arb: two-lane FIFO buffered merge with round-robin arbitration and registered output.
module mux_l2_arb #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn0,
  input  logic              validIn0,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic              validIn1,
  input  logic              pause,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              selOut,
  output logic              full0,
  output logic              full1,
  output logic              almostFull0,
  output logic              almostFull1,
  output logic              overflow0,
  output logic              overflow1
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF = (AW+1)'(DEPTH-1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [AW-1:0] wrPtr0, rdPtr0, wrPtr1, rdPtr1;
  logic [AW:0] count0, count1;
  logic lastServed, pop0, pop1, push0, push1;
  // Pop is decided on pre-edge counts, so a word written this edge cannot be popped until the next one.
  always_comb begin
    pop0 = !pause && |count0 && (~|count1 || lastServed);
    pop1 = !pause && |count1 && (~|count0 || !lastServed);
    push0 = reset && validIn0 && (count0 != CNT_FULL || pop0);
    push1 = reset && validIn1 && (count1 != CNT_FULL || pop1);
  end
  assign full0 = count0 == CNT_FULL;
  assign full1 = count1 == CNT_FULL;
  assign almostFull0 = count0 >= CNT_AF;
  assign almostFull1 = count1 >= CNT_AF;
  always_ff @(posedge clk) begin
    if (push0) mem0[wrPtr0] <= dataIn0;
    if (push1) mem1[wrPtr1] <= dataIn1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr0 <= '0;
      rdPtr0 <= '0;
      wrPtr1 <= '0;
      rdPtr1 <= '0;
      count0 <= '0;
      count1 <= '0;
      lastServed <= 1'b1;
      dataOut <= '0;
      validOut <= 1'b0;
      selOut <= 1'b0;
      overflow0 <= 1'b0;
      overflow1 <= 1'b0;
    end else begin
      if (push0) wrPtr0 <= wrPtr0 + PTR_ONE;
      if (pop0) rdPtr0 <= rdPtr0 + PTR_ONE;
      if (push1) wrPtr1 <= wrPtr1 + PTR_ONE;
      if (pop1) rdPtr1 <= rdPtr1 + PTR_ONE;
      if (push0 != pop0) count0 <= push0 ? count0 + CNT_ONE : count0 - CNT_ONE;
      if (push1 != pop1) count1 <= push1 ? count1 + CNT_ONE : count1 - CNT_ONE;
      if (validIn0 && !push0) overflow0 <= 1'b1;
      if (validIn1 && !push1) overflow1 <= 1'b1;
      validOut <= pop0 | pop1;
      if (pop0 | pop1) begin
        dataOut <= pop0 ? mem0[rdPtr0] : mem1[rdPtr1];
        selOut <= pop1;
        lastServed <= pop1;
      end
    end
  end
endmodule

// File: tb/tb_mux_l2_arb.sv
// tb_mux_l2_arb: queue-based reference model feeding a scoreboard; a negedge monitor checks every cycle.
module tb_mux_l2_arb;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] dataIn0 = '0, dataIn1 = '0;
  logic validIn0 = 1'b0, validIn1 = 1'b0, pause = 1'b0;
  logic [DW-1:0] dataOut;
  logic validOut, selOut, full0, full1, almostFull0, almostFull1, overflow0, overflow1;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0] expQ[$];
  logic ls = 1'b1;
  logic expValid = 1'b0;
  logic ovf0 = 1'b0, ovf1 = 1'b0;
  logic [DW-1:0] lastData = '0;
  logic lastSel = 1'b0;

  mux_l2_arb #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .dataIn0(dataIn0), .validIn0(validIn0),
    .dataIn1(dataIn1), .validIn1(validIn1),
    .pause(pause),
    .dataOut(dataOut), .validOut(validOut), .selOut(selOut),
    .full0(full0), .full1(full1),
    .almostFull0(almostFull0), .almostFull1(almostFull1),
    .overflow0(overflow0), .overflow1(overflow1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    expQ.delete();
    ls = 1'b1;
    expValid = 1'b0;
    ovf0 = 1'b0;
    ovf1 = 1'b0;
    lastData = '0;
    lastSel = 1'b0;
  endtask

  // Reference: serve one non-empty lane per unpaused edge (alternating on a tie), then append writes if room remains.
  always @(posedge clk) begin
    if (reset) begin
      logic [DW-1:0] d;
      logic lane;
      if (!pause && (q0.size() > 0 || q1.size() > 0)) begin
        lane = (q0.size() > 0 && q1.size() > 0) ? !ls : (q1.size() > 0);
        d = lane ? q1.pop_front() : q0.pop_front();
        ls = lane;
        expQ.push_back({lane, d});
        expValid = 1'b1;
      end else expValid = 1'b0;
      if (validIn0) begin
        if (q0.size() < DEPTH) q0.push_back(dataIn0);
        else ovf0 = 1'b1;
      end
      if (validIn1) begin
        if (q1.size() < DEPTH) q1.push_back(dataIn1);
        else ovf1 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    chk("validOut", 32'(validOut), 32'(expValid));
    if (validOut && expValid) begin
      if (expQ.size() == 0) chk("scoreboardEmpty", 32'(1), 32'(0));
      else begin
        e = expQ.pop_front();
        chk("dataOut", 32'(dataOut), 32'(e[DW-1:0]));
        chk("selOut", 32'(selOut), 32'(e[DW]));
        lastData = e[DW-1:0];
        lastSel = e[DW];
      end
    end else if (!validOut) begin
      chk("dataOutHold", 32'(dataOut), 32'(lastData));
      chk("selOutHold", 32'(selOut), 32'(lastSel));
    end
    chk("full0", 32'(full0), 32'(q0.size() == DEPTH));
    chk("full1", 32'(full1), 32'(q1.size() == DEPTH));
    chk("almostFull0", 32'(almostFull0), 32'(q0.size() >= DEPTH - 1));
    chk("almostFull1", 32'(almostFull1), 32'(q1.size() >= DEPTH - 1));
    chk("overflow0", 32'(overflow0), 32'(ovf0));
    chk("overflow1", 32'(overflow1), 32'(ovf1));
  end

  task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1, input logic p);
    @(posedge clk);
    #1;
    validIn0 = v0;
    dataIn0 = d0;
    validIn1 = v1;
    dataIn1 = d1;
    pause = p;
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, p);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    // single word
    drive(1'b1, 8'hA5, 1'b0, '0, 1'b0);
    idle(3, 1'b0);
    // tie round-robin
    drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h11, 1'b1, 8'h21, 1'b0);
    idle(5, 1'b0);
    // overflow on lane 1 while paused
    for (int i = 1; i <= 5; i++) drive(1'b0, '0, 1'b1, 8'(i), 1'b1);
    idle(1, 1'b1);
    idle(6, 1'b0);
    // lane 0 full, write lands on the same edge as a pop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, '0, 1'b1);
    drive(1'b1, 8'h99, 1'b0, '0, 1'b0);
    idle(7, 1'b0);
    // pause in the middle of a stream
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h50 + 8'(i), 1'b1, 8'h60 + 8'(i), 1'b0);
    idle(3, 1'b1);
    idle(8, 1'b0);
    // asynchronous reset with both lanes holding data
    for (int i = 0; i < 2; i++) drive(1'b1, 8'h70 + 8'(i), 1'b1, 8'h80 + 8'(i), 1'b1);
    drive(1'b1, 8'h72, 1'b0, '0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    chk("rstValidOut", 32'(validOut), 32'(0));
    chk("rstDataOut", 32'(dataOut), 32'(0));
    chk("rstSelOut", 32'(selOut), 32'(0));
    chk("rstFull", 32'({full0, full1, almostFull0, almostFull1}), 32'(0));
    chk("rstOverflow", 32'({overflow0, overflow1}), 32'(0));
    validIn0 = 1'b0;
    validIn1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(4, 1'b0);
    // randomized traffic with rising input load so the lanes fill and overflow
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 100; i++)
        drive($urandom_range(0, 99) < 30 + 20 * b, 8'($urandom),
              $urandom_range(0, 99) < 25 + 20 * b, 8'($urandom),
              $urandom_range(0, 3) == 0);
    idle(2 * DEPTH + 4, 1'b0);
    @(posedge clk);
    #1;
    chk("scoreboardDrained", 32'(expQ.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
